// File: rtl/stage_if_pkg.sv
// Shared widths, FSM encoding and output payload for the instruction-fetch stage.
package stage_if_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned INST_W     = 32;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned INST_BYTES = 4;

  // addi x0,x0,0
  localparam logic [INST_W-1:0] NOP_DEFAULT = 32'h0000_0013;

  typedef enum logic [0:0] {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_e;

  // Instruction handed to decode
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } if_out_t;

endpackage

// File: rtl/stage_if.sv
// Instruction fetch: assembles 32-bit words from four little-endian byte reads,
// presents them to decode, holds under stall and flushes on redirect.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INST_W-1:0] NOP_INST = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              mem_grant_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [BYTE_W-1:0] mem_rdata_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic              pend_q, pend_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic              valid_q, valid_d;
  if_out_t           out_q, out_d;

  logic              out_free;
  logic              last_byte;
  logic [INST_W-1:0] word;
  logic [ADDR_W-1:0] next_pc;

  assign out_free  = !valid_q || !stall_i;
  assign last_byte = pend_q && (rx_cnt_q == CNT_W'(INST_BYTES - 1));
  assign word      = {mem_rdata_i, buf_q[INST_W-BYTE_W-1:0]};
  assign next_pc   = fetch_pc_q + ADDR_W'(INST_BYTES);

  assign valid_o = valid_q;
  assign pc_o    = out_q.pc;
  assign inst_o  = out_q.inst;

  // Next-state, byte assembly, output load and memory request
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issue_cnt_d = issue_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    pend_d      = 1'b0;
    buf_d       = buf_q;
    valid_d     = valid_q;
    out_d       = out_q;
    mem_req_o   = 1'b0;
    mem_addr_o  = fetch_pc_q + ADDR_W'(issue_cnt_q);

    // Presented instruction taken by decode; may be overwritten below
    if (valid_q && !stall_i) begin
      valid_d    = 1'b0;
      out_d.inst = NOP_INST;
    end

    if (jump_i) begin
      // Redirect flushes everything; any byte still in flight is orphaned
      state_d     = IF_FETCH;
      fetch_pc_d  = jump_addr_i;
      issue_cnt_d = '0;
      rx_cnt_d    = '0;
      buf_d       = '0;
      valid_d     = 1'b0;
      out_d.inst  = NOP_INST;
    end else begin
      case (state_q)
        IF_FETCH: begin
          mem_req_o = (issue_cnt_q < CNT_W'(INST_BYTES));
          if (pend_q) begin
            buf_d[{rx_cnt_q[1:0], 3'b000} +: BYTE_W] = mem_rdata_i;
            rx_cnt_d = rx_cnt_q + CNT_W'(1);
          end
          if (last_byte) begin
            if (out_free) begin
              valid_d     = 1'b1;
              out_d.pc    = fetch_pc_q;
              out_d.inst  = word;
              fetch_pc_d  = next_pc;
              issue_cnt_d = '0;
              rx_cnt_d    = '0;
              // Overlap: byte 0 of the next word goes out this cycle
              mem_req_o   = 1'b1;
              mem_addr_o  = next_pc;
            end else begin
              state_d = IF_HOLD;
            end
          end
          if (mem_req_o && mem_grant_i) begin
            issue_cnt_d = issue_cnt_d + CNT_W'(1);
            pend_d      = 1'b1;
          end
        end
        IF_HOLD: begin
          if (out_free) begin
            valid_d     = 1'b1;
            out_d.pc    = fetch_pc_q;
            out_d.inst  = buf_q;
            fetch_pc_d  = next_pc;
            issue_cnt_d = '0;
            rx_cnt_d    = '0;
            state_d     = IF_FETCH;
          end
        end
        default: state_d = IF_FETCH;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IF_FETCH;
      fetch_pc_q  <= RESET_PC;
      issue_cnt_q <= '0;
      rx_cnt_q    <= '0;
      pend_q      <= 1'b0;
      buf_q       <= '0;
      valid_q     <= 1'b0;
      out_q       <= if_out_t'{pc: '0, inst: NOP_INST};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issue_cnt_q <= issue_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      pend_q      <= pend_d;
      buf_q       <= buf_d;
      valid_q     <= valid_d;
      out_q       <= out_d;
    end
  end

endmodule
